// File: rtl/irq_edge_conditioner.sv
// irq_edge_conditioner: per-line synchroniser, glitch filter and minimum-high stretcher.
// Optional feature macro: IRQ_COND_SYNC_EN (two-flop synchroniser on each irq_raw_in bit).
module irq_edge_conditioner #(
  parameter int N_IRQ         = 32,
  parameter int FILTER_CYCLES = 4,
  parameter int MIN_HIGH      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_raw_in,
  input  logic [N_IRQ-1:0] irq_enable_in,
  output logic [N_IRQ-1:0] irq_cond_out,
  output logic [N_IRQ-1:0] irq_rise_pulse_out
);

  localparam logic [7:0] FILT_LAST = 8'(FILTER_CYCLES - 1);
  localparam logic [7:0] HIGH_MIN  = 8'(MIN_HIGH);

  // High-time counter step: counts while the output is high, saturating at the minimum.
  function automatic logic [7:0] hcnt_step(input logic level, input logic [7:0] cnt);
    if (!level) begin
      hcnt_step = 8'd0;
    end else if (cnt >= HIGH_MIN) begin
      hcnt_step = HIGH_MIN;
    end else begin
      hcnt_step = cnt + 8'd1;
    end
  endfunction

  logic [N_IRQ-1:0] sample_s;

`ifdef IRQ_COND_SYNC_EN
  logic [N_IRQ-1:0] sync1_r;
  logic [N_IRQ-1:0] sync2_r;

  // Two-flop synchroniser bringing asynchronous sources into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= {N_IRQ{1'b0}};
      sync2_r <= {N_IRQ{1'b0}};
    end else begin
      sync1_r <= irq_raw_in;
      sync2_r <= sync1_r;
    end
  end

  assign sample_s = sync2_r;
`else
  assign sample_s = irq_raw_in;
`endif

  for (genvar i = 0; i < N_IRQ; i++) begin : g_line
    logic       o_r;
    logic       o_nxt_s;
    logic       pulse_r;
    logic       pulse_nxt_s;
    logic [7:0] fcnt_r;
    logic [7:0] fcnt_nxt_s;
    logic [7:0] hcnt_r;
    logic [7:0] hcnt_nxt_s;

    // Filter and stretch decision; the filter restarts whenever the output changes,
    // so a fall needs the same number of stable samples as a rise.
    always_comb begin
      o_nxt_s     = o_r;
      pulse_nxt_s = 1'b0;
      fcnt_nxt_s  = fcnt_r;
      hcnt_nxt_s  = hcnt_r;
      if (!irq_enable_in[i]) begin
        o_nxt_s    = 1'b0;
        fcnt_nxt_s = 8'd0;
        hcnt_nxt_s = 8'd0;
      end else if (sample_s[i] == o_r) begin
        fcnt_nxt_s = 8'd0;
        hcnt_nxt_s = hcnt_step(o_r, hcnt_r);
      end else if (fcnt_r < FILT_LAST) begin
        fcnt_nxt_s = fcnt_r + 8'd1;
        hcnt_nxt_s = hcnt_step(o_r, hcnt_r);
      end else if (!o_r) begin
        o_nxt_s     = 1'b1;
        pulse_nxt_s = 1'b1;
        fcnt_nxt_s  = 8'd0;
        hcnt_nxt_s  = 8'd1;
      end else if (hcnt_r >= HIGH_MIN) begin
        o_nxt_s    = 1'b0;
        fcnt_nxt_s = 8'd0;
        hcnt_nxt_s = 8'd0;
      end else begin
        // Qualified fall held off until the minimum high time has elapsed.
        fcnt_nxt_s = fcnt_r;
        hcnt_nxt_s = hcnt_step(o_r, hcnt_r);
      end
    end

    // Per-line state and registered outputs.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        o_r     <= 1'b0;
        pulse_r <= 1'b0;
        fcnt_r  <= 8'd0;
        hcnt_r  <= 8'd0;
      end else begin
        o_r     <= o_nxt_s;
        pulse_r <= pulse_nxt_s;
        fcnt_r  <= fcnt_nxt_s;
        hcnt_r  <= hcnt_nxt_s;
      end
    end

    assign irq_cond_out[i]       = o_r;
    assign irq_rise_pulse_out[i] = pulse_r;
  end

endmodule

// File: tb/tb_irq_edge_conditioner.sv
// Directed bench for irq_edge_conditioner: two instances (filter 4 / min-high 2, and
// filter 1 / min-high 6); latencies adapt to whether IRQ_COND_SYNC_EN is defined.
module tb_irq_edge_conditioner;

`ifdef IRQ_COND_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int FA    = 4;
  localparam int MA    = 2;
  localparam int FB    = 1;
  localparam int MB    = 6;
  localparam int LAT_A = FA - 1 + SYNC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] raw_a, en_a, cond_a, pulse_a;
  logic [31:0] raw_b, en_b, cond_b, pulse_b;

  int checks = 0;
  int errors = 0;
  int high_cnt;
  int pulse_cnt;

  always #5 clk = ~clk;

  irq_edge_conditioner #(.N_IRQ(32), .FILTER_CYCLES(FA), .MIN_HIGH(MA)) dut_a (
    .clk                (clk),
    .rst_n              (rst_n),
    .irq_raw_in         (raw_a),
    .irq_enable_in      (en_a),
    .irq_cond_out       (cond_a),
    .irq_rise_pulse_out (pulse_a)
  );

  irq_edge_conditioner #(.N_IRQ(32), .FILTER_CYCLES(FB), .MIN_HIGH(MB)) dut_b (
    .clk                (clk),
    .rst_n              (rst_n),
    .irq_raw_in         (raw_b),
    .irq_enable_in      (en_b),
    .irq_cond_out       (cond_b),
    .irq_rise_pulse_out (pulse_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with every raw line high: outputs must stay clear.
    rst_n = 1'b0;
    raw_a = 32'hFFFF_FFFF;
    raw_b = 32'hFFFF_FFFF;
    en_a  = 32'hFFFF_FFFF;
    en_b  = 32'hFFFF_FFFF;
    repeat (3) step();
    chk("reset_cond_a", cond_a, 32'h0);
    chk("reset_pulse_a", pulse_a, 32'h0);
    chk("reset_cond_b", cond_b, 32'h0);
    chk("reset_pulse_b", pulse_b, 32'h0);
    raw_a = 32'h0;
    raw_b = 32'h0;
    rst_n = 1'b1;
    repeat (4) step();
    chk("idle_cond_a", cond_a, 32'h0);

    // Steady event on line 0.
    raw_a = 32'h0000_0001;
    repeat (LAT_A) step();
    chk("steady_pre_rise", cond_a, 32'h0);
    step();
    chk("steady_rise", cond_a, 32'h0000_0001);
    chk("steady_pulse", pulse_a, 32'h0000_0001);
    step();
    chk("steady_pulse_end", pulse_a, 32'h0);
    chk("steady_hold", cond_a, 32'h0000_0001);
    repeat (5) step();
    chk("steady_hold_long", cond_a, 32'h0000_0001);
    raw_a = 32'h0;
    repeat (LAT_A) step();
    chk("steady_pre_fall", cond_a, 32'h0000_0001);
    step();
    chk("steady_fall", cond_a, 32'h0);

    // Glitch of FA-1 cycles on line 5 is discarded.
    raw_a = 32'h0000_0020;
    high_cnt  = 0;
    pulse_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (k == FA - 2) raw_a = 32'h0;
      high_cnt  += int'(cond_a[5]);
      pulse_cnt += int'(pulse_a[5]);
    end
    chk("glitch_no_high", 32'(high_cnt), 32'd0);
    chk("glitch_no_pulse", 32'(pulse_cnt), 32'd0);

    // Pulse of exactly FA cycles on line 5: one rise, high for at least MA cycles.
    raw_a = 32'h0000_0020;
    high_cnt  = 0;
    pulse_cnt = 0;
    for (int k = 0; k < 24; k++) begin
      step();
      if (k == FA - 1) raw_a = 32'h0;
      high_cnt  += int'(cond_a[5]);
      pulse_cnt += int'(pulse_a[5]);
    end
    chk("exact_min_high", 32'(high_cnt >= MA), 32'd1);
    chk("exact_one_pulse", 32'(pulse_cnt), 32'd1);
    chk("exact_fell", cond_a, 32'h0);

    // Stretch: one-cycle pulse on line 31 of instance B is held high for MB cycles.
    raw_b = 32'h8000_0000;
    high_cnt  = 0;
    pulse_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (k == 0) raw_b = 32'h0;
      high_cnt  += int'(cond_b[31]);
      pulse_cnt += int'(pulse_b[31]);
    end
    chk("stretch_high_cycles", 32'(high_cnt), 32'(MB));
    chk("stretch_one_pulse", 32'(pulse_cnt), 32'd1);
    chk("stretch_idle", cond_b, 32'h0);

    // Enable masking on line 7.
    raw_a = 32'h0000_0080;
    repeat (LAT_A + 1) step();
    chk("enable_rise", cond_a, 32'h0000_0080);
    en_a = 32'hFFFF_FF7F;
    step();
    chk("enable_drop_cond", cond_a, 32'h0);
    chk("enable_drop_pulse", pulse_a, 32'h0);
    repeat (3) step();
    chk("enable_masked", cond_a, 32'h0);
    en_a = 32'hFFFF_FFFF;
    repeat (FA - 1) step();
    chk("reenable_pre_rise", cond_a, 32'h0);
    step();
    chk("reenable_rise", cond_a, 32'h0000_0080);
    chk("reenable_pulse", pulse_a, 32'h0000_0080);
    raw_a = 32'h0;
    repeat (10) step();
    chk("enable_cleared", cond_a, 32'h0);

    // All lines rise together.
    raw_a = 32'hFFFF_FFFF;
    repeat (LAT_A) step();
    chk("simul_pre_rise", cond_a, 32'h0);
    step();
    chk("simul_cond", cond_a, 32'hFFFF_FFFF);
    chk("simul_pulse", pulse_a, 32'hFFFF_FFFF);
    step();
    chk("simul_pulse_end", pulse_a, 32'h0);
    raw_a = 32'h0;
    repeat (10) step();
    chk("simul_cleared", cond_a, 32'h0);

    // Reset while lines 0-1 are high and lines 2-3 are mid-filter.
    raw_a = 32'h0000_0003;
    repeat (LAT_A + 1) step();
    chk("prereset_high", cond_a, 32'h0000_0003);
    raw_a = 32'h0000_000F;
    repeat (2) step();
    rst_n = 1'b0;
    step();
    chk("midreset_cond", cond_a, 32'h0);
    chk("midreset_pulse", pulse_a, 32'h0);
    rst_n = 1'b1;
    repeat (LAT_A) step();
    chk("postreset_pre_rise", cond_a, 32'h0);
    step();
    chk("postreset_rise", cond_a, 32'h0000_000F);
    chk("postreset_pulse", pulse_a, 32'h0000_000F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
